axis_i2c_slave: RTL and testbench

//  I2C target (responder) answering a single 7-bit address; the counterpart of axis_i2c_master.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/axis_if.sv | 13 +
 rtl/i2c_line_sync.sv | 31 +++
 rtl/axis_i2c_slave.sv | 211 +++++++++++++++++++++
 tb/tb_axis_i2c_slave.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus constants and the target FSM state encoding.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StWaitStop
  } i2c_slv_state_t;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle (tdata/tvalid/tready) with source and sink views.
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/i2c_line_sync.sv
// Synchroniser for one I2C line into clk_i, with single-cycle rise/fall pulses.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Idle bus is pulled high, so reset to 1 to avoid a spurious edge at release.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/axis_i2c_slave.sv
// I2C target for one 7-bit address: writes leave on m_axis, reads are pulled from s_axis.
module axis_i2c_slave
  import i2c_pkg::*;
#(
  parameter int unsigned      DATA_WIDTH  = 8,
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h3C,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic   clk_i,
  input  logic   arstn_i,
  input  logic   i2c_scl_i,
  inout  wire    i2c_sda_io,
  axis_if.slave  s_axis,
  axis_if.master m_axis,
  output logic   busy_o,
  output logic   rd_underflow_o
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .line_i  (i2c_scl_i),
    .level_o (scl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .line_i  (i2c_sda_io),
    .level_o (sda),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  logic start, stop;
  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  i2c_slv_state_t        state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic tvalid_q, tvalid_d;
  logic sda_oe_q, sda_oe_d;
  logic busy_q, busy_d;
  logic rw_q, rw_d;
  logic slot_q, slot_d;     // first fall of the current ack slot already seen / master ACKed
  logic load_q, load_d;     // written byte completed last cycle
  logic ack_ok_q, ack_ok_d;
  logic unf_q;
  logic rd_load;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      rw_q     <= 1'b0;
      slot_q   <= 1'b0;
      load_q   <= 1'b0;
      ack_ok_q <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      rw_q     <= rw_d;
      slot_q   <= slot_d;
      load_q   <= load_d;
      ack_ok_q <= ack_ok_d;
      unf_q    <= rd_load & ~s_axis.tvalid;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    rw_d     = rw_q;
    slot_d   = slot_q;
    load_d   = 1'b0;
    ack_ok_d = ack_ok_q;
    rd_load  = 1'b0;

    if (tvalid_q && m_axis.tready) tvalid_d = 1'b0;

    if (start) begin
      state_d  = StAddr;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      slot_d   = 1'b0;
    end else if (stop) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: if (scl_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sda};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rw_d    = sda;
            slot_d  = 1'b0;
            state_d = (shift_q[ADDR_W-1:0] == SLAVE_ADDR) ? StAddrAck : StWaitStop;
          end
        end
        StAddrAck: if (scl_fall) begin
          if (!slot_q) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            slot_d   = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            if (rw_q) begin
              rd_load = 1'b1;
              state_d = StRdData;
            end else begin
              state_d = StWrData;
            end
          end
        end
        StWrData: if (scl_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sda};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            load_d  = 1'b1;
            slot_d  = 1'b0;
            state_d = StWrAck;
          end
        end
        StWrAck: begin
          // A byte still waiting in the register is kept; the new one is dropped and NACKed.
          if (load_q) begin
            if (!tvalid_q || m_axis.tready) begin
              tvalid_d = 1'b1;
              tdata_d  = shift_q;
              ack_ok_d = 1'b1;
            end else begin
              ack_ok_d = 1'b0;
            end
          end
          if (scl_fall) begin
            if (!slot_q) begin
              sda_oe_d = ack_ok_q;
              slot_d   = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = StWrData;
            end
          end
        end
        StRdData: if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            slot_d   = 1'b0;
            state_d  = StRdAck;
          end else begin
            shift_d  = shift_q << 1;
            sda_oe_d = ~shift_q[DATA_WIDTH-2];
            cnt_d    = cnt_q + 3'd1;
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda == I2C_NACK) state_d = StWaitStop;
            else                 slot_d  = 1'b1;
          end else if (scl_fall && slot_q) begin
            rd_load = 1'b1;
            cnt_d   = '0;
            state_d = StRdData;
          end
        end
        default: ;
      endcase
    end

    // Load the next read byte and present its MSB at the fall that ends the ack slot.
    if (rd_load) begin
      shift_d  = s_axis.tvalid ? s_axis.tdata : '1;
      sda_oe_d = ~shift_d[DATA_WIDTH-1];
    end
  end

  assign i2c_sda_io     = sda_oe_q ? 1'b0 : 1'bz;
  assign s_axis.tready  = rd_load & s_axis.tvalid;
  assign m_axis.tdata   = tdata_q;
  assign m_axis.tvalid  = tvalid_q;
  assign busy_o         = busy_q;
  assign rd_underflow_o = unf_q;

endmodule

// File: tb/tb_axis_i2c_slave.sv
// Directed bench: a bit-banged I2C master exercises write, read, underflow, backpressure, Sr, reset.
module tb_axis_i2c_slave;

  localparam int unsigned Q = 20;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic arstn;
  logic scl_m;
  logic sda_m_oe;
  logic m_rdy;
  logic busy, unf;
  wire  sda;

  assign sda = sda_m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  axis_if #(.DATA_WIDTH(8)) s_axis ();
  axis_if #(.DATA_WIDTH(8)) m_axis ();

  axis_i2c_slave #(
    .DATA_WIDTH  (8),
    .SLAVE_ADDR  (7'h3C),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .i2c_scl_i      (scl_m),
    .i2c_sda_io     (sda),
    .s_axis         (s_axis),
    .m_axis         (m_axis),
    .busy_o         (busy),
    .rd_underflow_o (unf)
  );

  always #5 clk = ~clk;

  // Read-data source
  logic [7:0] src_mem [16];
  int src_cnt = 0;
  int src_idx = 0;
  assign s_axis.tvalid = (src_idx < src_cnt);
  assign s_axis.tdata  = src_mem[src_idx[3:0]];
  assign m_axis.tready = m_rdy;
  always @(posedge clk) if (s_axis.tvalid && s_axis.tready) src_idx <= src_idx + 1;

  // Monitors
  int rdy_cnt = 0, unf_cnt = 0, low_cnt = 0, busy_cnt = 0;
  logic [7:0] cap_q [$];
  always @(negedge clk) begin
    if (s_axis.tready) rdy_cnt <= rdy_cnt + 1;
    if (unf) unf_cnt <= unf_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (!sda_m_oe && sda === 1'b0) low_cnt <= low_cnt + 1;
    if (m_axis.tvalid && m_axis.tready) cap_q.push_back(m_axis.tdata);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start();
    sda_m_oe = 1'b0; tick(Q);
    scl_m = 1'b1;    tick(Q);
    sda_m_oe = 1'b1; tick(Q);
    scl_m = 1'b0;    tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m_oe = 1'b1; tick(Q);
    scl_m = 1'b1;    tick(Q);
    sda_m_oe = 1'b0; tick(Q);
  endtask

  task automatic wbit(input logic b);
    sda_m_oe = ~b; tick(Q);
    scl_m = 1'b1;  tick(2 * Q);
    scl_m = 1'b0;  tick(Q);
  endtask

  task automatic rbit(output logic b);
    sda_m_oe = 1'b0; tick(Q);
    scl_m = 1'b1;    tick(Q);
    b = sda;         tick(Q);
    scl_m = 1'b0;    tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(mack);
    sda_m_oe = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int c0, r0, u0, l0, b0, base;

    arstn = 1'b0; scl_m = 1'b1; sda_m_oe = 1'b0; m_rdy = 1'b1;
    tick(5);
    check("rst_tvalid", m_axis.tvalid, 0);
    check("rst_tdata", m_axis.tdata, 0);
    check("rst_tready", s_axis.tready, 0);
    check("rst_busy", busy, 0);
    check("rst_underflow", unf, 0);
    check("rst_sda", sda, 1);
    arstn = 1'b1;
    tick(5);

    // Write A5, 5A
    c0 = cap_q.size();
    i2c_start();
    wbyte(8'h78, ack); check("wr_addr_ack", ack, 0);
    check("wr_busy_on", busy, 1);
    wbyte(8'hA5, ack); check("wr_a5_ack", ack, 0);
    wbyte(8'h5A, ack); check("wr_5a_ack", ack, 0);
    i2c_stop();
    tick(4);
    check("wr_busy_off", busy, 0);
    check("wr_count", cap_q.size() - c0, 2);
    check("wr_byte0", cap_q[c0], 8'hA5);
    check("wr_byte1", cap_q[c0 + 1], 8'h5A);

    // Wrong address
    c0 = cap_q.size(); l0 = low_cnt; b0 = busy_cnt;
    i2c_start();
    wbyte(8'h20, ack); check("bad_addr_nack", ack, 1);
    wbyte(8'h11, ack); check("bad_data_nack", ack, 1);
    i2c_stop();
    tick(4);
    check("bad_sda_driven", low_cnt - l0, 0);
    check("bad_busy", busy_cnt - b0, 0);
    check("bad_axis", cap_q.size() - c0, 0);

    // Read C3, 3C
    base = src_idx;
    src_mem[base[3:0]] = 8'hC3;
    src_mem[4'(base + 1)] = 8'h3C;
    src_cnt = base + 2;
    r0 = rdy_cnt; u0 = unf_cnt;
    i2c_start();
    wbyte(8'h79, ack); check("rd_addr_ack", ack, 0);
    rbyte(d, 1'b0); check("rd_byte0", d, 8'hC3);
    rbyte(d, 1'b1); check("rd_byte1", d, 8'h3C);
    i2c_stop();
    tick(4);
    check("rd_tready_pulses", rdy_cnt - r0, 2);
    check("rd_no_underflow", unf_cnt - u0, 0);

    // Underflow
    r0 = rdy_cnt; u0 = unf_cnt;
    i2c_start();
    wbyte(8'h79, ack); check("unf_addr_ack", ack, 0);
    rbyte(d, 1'b1); check("unf_byte", d, 8'hFF);
    i2c_stop();
    tick(4);
    check("unf_pulse", unf_cnt - u0, 1);
    check("unf_no_tready", rdy_cnt - r0, 0);

    // Backpressure
    m_rdy = 1'b0;
    c0 = cap_q.size();
    i2c_start();
    wbyte(8'h78, ack); check("bp_addr_ack", ack, 0);
    wbyte(8'h01, ack); check("bp_01_ack", ack, 0);
    wbyte(8'h02, ack); check("bp_02_nack", ack, 1);
    i2c_stop();
    tick(4);
    check("bp_tvalid_held", m_axis.tvalid, 1);
    check("bp_tdata_held", m_axis.tdata, 8'h01);
    check("bp_no_xfer", cap_q.size() - c0, 0);
    m_rdy = 1'b1;
    tick(3);
    check("bp_drained", m_axis.tvalid, 0);
    check("bp_xfer_count", cap_q.size() - c0, 1);
    check("bp_xfer_data", cap_q[c0], 8'h01);

    // Repeated START, then reset in the middle of a read
    c0 = cap_q.size();
    base = src_idx;
    src_mem[base[3:0]] = 8'h96;
    src_mem[4'(base + 1)] = 8'h00;
    src_cnt = base + 2;
    i2c_start();
    wbyte(8'h78, ack); check("sr_addr_ack", ack, 0);
    wbyte(8'h10, ack); check("sr_10_ack", ack, 0);
    i2c_start();
    check("sr_busy_clear", busy, 0);
    check("sr_wr_data", cap_q[c0], 8'h10);
    wbyte(8'h79, ack); check("sr_rd_addr_ack", ack, 0);
    check("sr_busy_on", busy, 1);
    rbyte(d, 1'b0); check("sr_rd_byte", d, 8'h96);
    tick(1);
    check("sr_drive_low", sda, 0);
    arstn = 1'b0;
    #1;
    check("rst_sda_release", sda, 1);
    check("rst_busy_clear", busy, 0);
    tick(2);
    arstn = 1'b1;
    scl_m = 1'b1;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
